// File: rtl/rf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rf_wb_arbiter
// Purpose  : Register-file write port driver. Merges ALU results (priority)
//            with queued memory results; bounded starvation of the queue.
// Revision : 1.0 - initial release
// ============================================================================
module rf_wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4,
    parameter int STARVE_MAX = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              alu_valid,
    output logic                              alu_ready,
    input  logic [ADDR_W-1:0]                 alu_rd,
    input  logic [DATA_W-1:0]                 alu_data,
    input  logic                              mem_valid,
    output logic                              mem_ready,
    input  logic [ADDR_W-1:0]                 mem_rd,
    input  logic [DATA_W-1:0]                 mem_data,
    output logic                              wb_we,
    output logic [ADDR_W-1:0]                 wb_addr,
    output logic [DATA_W-1:0]                 wb_data,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_count
);

    localparam int c_PTR_W = $clog2(FIFO_DEPTH);
    localparam int c_CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int c_STV_W = $clog2(STARVE_MAX + 1);
    localparam logic [c_CNT_W-1:0] c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_STV_W-1:0] c_STV_MAX = c_STV_W'(STARVE_MAX);

    logic [ADDR_W-1:0]  rd_mem_q  [FIFO_DEPTH];
    logic [ADDR_W-1:0]  rd_mem_d  [FIFO_DEPTH];
    logic [DATA_W-1:0]  dat_mem_q [FIFO_DEPTH];
    logic [DATA_W-1:0]  dat_mem_d [FIFO_DEPTH];
    logic [c_PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_CNT_W-1:0] count_q, count_d;
    logic [c_STV_W-1:0] starve_q, starve_d;
    logic               wb_we_q, wb_we_d;
    logic [ADDR_W-1:0]  wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]  wb_data_q, wb_data_d;

    logic w_nonempty;
    logic w_force;
    logic w_push;
    logic w_pop;

    // Handshakes use only registered state, so a pop never frees a slot the
    // same cycle and ready never depends on valid.
    always_comb begin
        w_nonempty = (count_q != '0);
        w_force    = w_nonempty && (starve_q == c_STV_MAX);
        alu_ready  = !rst && !w_force;
        mem_ready  = !rst && (count_q != c_FULL);
        w_push     = mem_valid && mem_ready && (mem_rd != '0);
        w_pop      = w_force || (!alu_valid && w_nonempty);
    end

    always_comb begin
        wb_we_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        starve_d  = starve_q;
        if (w_pop) begin
            wb_we_d   = 1'b1;
            wb_addr_d = rd_mem_q[rd_ptr_q];
            wb_data_d = dat_mem_q[rd_ptr_q];
            starve_d  = '0;
        end else if (alu_valid) begin
            wb_we_d = (alu_rd != '0);
            if (alu_rd != '0) begin
                wb_addr_d = alu_rd;
                wb_data_d = alu_data;
            end
            if (w_nonempty && (starve_q != c_STV_MAX)) begin
                starve_d = starve_q + c_STV_W'(1);
            end
        end
        if (!w_nonempty) begin
            starve_d = '0;
        end
    end

    always_comb begin
        rd_mem_d  = rd_mem_q;
        dat_mem_d = dat_mem_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        if (w_push) begin
            rd_mem_d[wr_ptr_q]  = mem_rd;
            dat_mem_d[wr_ptr_q] = mem_data;
            wr_ptr_d            = wr_ptr_q + c_PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_PTR_W'(1);
        end
        case ({w_push, w_pop})
            2'b10:   count_d = count_q + c_CNT_W'(1);
            2'b01:   count_d = count_q - c_CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                rd_mem_q[i]  <= '0;
                dat_mem_q[i] <= '0;
            end
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            starve_q  <= '0;
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            rd_mem_q  <= rd_mem_d;
            dat_mem_q <= dat_mem_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

    assign wb_we      = wb_we_q;
    assign wb_addr    = wb_addr_q;
    assign wb_data    = wb_data_q;
    assign fifo_count = count_q;

endmodule
`default_nettype wire
